lsu_axi: RTL

- Load/store unit sitting directly downstream of the core's decode/execute stage.
- Takes one decoded load or store at a time and runs it as a single AXI4-Lite transaction on the core's master port.
- Byte/half stores get lane alignment and strobes; loads get lane extraction with sign or zero extension.
- Returns load data or an error flag to the core. The core stalls while req_ready is low.

---
 rtl/lsu_axi.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/lsu_axi.sv
// Load/store unit: runs one decoded RV32I load or store as a single AXI4-Lite
// transaction. It aligns store lanes and strobes, and extracts and extends load data.
//
// state  | meaning
// IDLE   | req_ready high, waiting for a request
// WRITE  | AW and W channels in flight, each drops on its own handshake
// WRESP  | bready high, waiting for the write response
// READ_A | arvalid high, waiting for arready
// READ_D | rready high, waiting for read data
// DONE   | one-cycle rsp_valid pulse with registered data/error
module lsu_axi #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    reset,

    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [2:0]              req_funct3,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,

    output logic                    rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,

    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,
    output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [2:0]              m_axi_awprot,

    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,
    output logic [DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,

    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready,
    input  logic [1:0]              m_axi_bresp,

    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,
    output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [2:0]              m_axi_arprot,

    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready,
    input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]              m_axi_rresp
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WRITE  = 3'd1;
    localparam logic [2:0] S_WRESP  = 3'd2;
    localparam logic [2:0] S_READ_A = 3'd3;
    localparam logic [2:0] S_READ_D = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    logic [2:0]              state;
    logic [2:0]              funct3_q;
    logic [1:0]              off_q;

    logic [1:0]              req_off;
    logic                    legal_f3;
    logic                    misaligned;
    logic                    req_ok;
    logic [ADDR_WIDTH-1:0]   word_addr;
    logic [DATA_WIDTH-1:0]   store_data;
    logic [DATA_WIDTH/8-1:0] store_strb;
    logic [DATA_WIDTH-1:0]   load_shift;
    logic [DATA_WIDTH-1:0]   load_data;
    logic                    aw_complete;
    logic                    w_complete;

    assign req_ready    = (state == S_IDLE);
    assign m_axi_awprot = 3'b000;
    assign m_axi_arprot = 3'b000;

    assign req_off   = req_addr[1:0];
    assign word_addr = {req_addr[ADDR_WIDTH-1:2], 2'b00};

    always_comb begin
        legal_f3 = 1'b0;
        if (req_we) begin
            legal_f3 = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                       (req_funct3 == 3'b010);
        end else begin
            legal_f3 = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                       (req_funct3 == 3'b010) || (req_funct3 == 3'b100) ||
                       (req_funct3 == 3'b101);
        end
    end

    // funct3[1:0] encodes the access size for both loads and stores
    assign misaligned = ((req_funct3[1:0] == 2'b01) && req_off[0]) ||
                        ((req_funct3[1:0] == 2'b10) && (req_off != 2'b00));
    assign req_ok     = legal_f3 && !misaligned;

    assign store_data = req_wdata << {req_off, 3'b000};

    always_comb begin
        store_strb = '0;
        case (req_funct3[1:0])
            2'b00:   store_strb = 4'b0001 << req_off;
            2'b01:   store_strb = 4'b0011 << req_off;
            default: store_strb = 4'b1111;
        endcase
    end

    assign load_shift = m_axi_rdata >> {off_q, 3'b000};

    always_comb begin
        load_data = load_shift;
        case (funct3_q)
            3'b000:  load_data = {{(DATA_WIDTH-8){load_shift[7]}}, load_shift[7:0]};
            3'b100:  load_data = {{(DATA_WIDTH-8){1'b0}}, load_shift[7:0]};
            3'b001:  load_data = {{(DATA_WIDTH-16){load_shift[15]}}, load_shift[15:0]};
            3'b101:  load_data = {{(DATA_WIDTH-16){1'b0}}, load_shift[15:0]};
            default: load_data = load_shift;
        endcase
    end

    // A channel counts as complete once its valid has dropped or it handshakes now
    assign aw_complete = !m_axi_awvalid || m_axi_awready;
    assign w_complete  = !m_axi_wvalid  || m_axi_wready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            funct3_q      <= 3'b000;
            off_q         <= 2'b00;
            rsp_valid     <= 1'b0;
            rsp_rdata     <= '0;
            rsp_err       <= 1'b0;
            m_axi_awvalid <= 1'b0;
            m_axi_awaddr  <= '0;
            m_axi_wvalid  <= 1'b0;
            m_axi_wdata   <= '0;
            m_axi_wstrb   <= '0;
            m_axi_bready  <= 1'b0;
            m_axi_arvalid <= 1'b0;
            m_axi_araddr  <= '0;
            m_axi_rready  <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        funct3_q <= req_funct3;
                        off_q    <= req_off;
                        if (!req_ok) begin
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                            state     <= S_DONE;
                        end else if (req_we) begin
                            m_axi_awaddr  <= word_addr;
                            m_axi_awvalid <= 1'b1;
                            m_axi_wdata   <= store_data;
                            m_axi_wstrb   <= store_strb;
                            m_axi_wvalid  <= 1'b1;
                            state         <= S_WRITE;
                        end else begin
                            m_axi_araddr  <= word_addr;
                            m_axi_arvalid <= 1'b1;
                            state         <= S_READ_A;
                        end
                    end
                end
                S_WRITE: begin
                    if (m_axi_awready) m_axi_awvalid <= 1'b0;
                    if (m_axi_wready)  m_axi_wvalid  <= 1'b0;
                    if (aw_complete && w_complete) begin
                        m_axi_bready <= 1'b1;
                        state        <= S_WRESP;
                    end
                end
                S_WRESP: begin
                    if (m_axi_bvalid) begin
                        m_axi_bready <= 1'b0;
                        rsp_err      <= (m_axi_bresp != 2'b00);
                        rsp_rdata    <= '0;
                        rsp_valid    <= 1'b1;
                        state        <= S_DONE;
                    end
                end
                S_READ_A: begin
                    if (m_axi_arready) begin
                        m_axi_arvalid <= 1'b0;
                        m_axi_rready  <= 1'b1;
                        state         <= S_READ_D;
                    end
                end
                S_READ_D: begin
                    if (m_axi_rvalid) begin
                        m_axi_rready <= 1'b0;
                        rsp_err      <= (m_axi_rresp != 2'b00);
                        rsp_rdata    <= (m_axi_rresp != 2'b00) ? '0 : load_data;
                        rsp_valid    <= 1'b1;
                        state        <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
